// File: rtl/pipe_in_funnel_tx.sv
// pipe_in_funnel_tx: takes one wide PipeIn beat and streams it out as a
// sequence of narrow words, least-significant word first. The final word is
// zero-padded above the top input bit. When the last word of a beat transfers,
// a new beat can be taken in the same cycle, so back-to-back beats produce an
// unbroken output stream.
module pipe_in_funnel_tx #(
    parameter int inWidth   = 144,
    parameter int dataWidth = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_enq__ENA,
    input  logic [inWidth-1:0]   in_enq_v,
    output logic                 in_enq__RDY,
    output logic                 out_enq__ENA,
    output logic [dataWidth-1:0] out_enq_v,
    input  logic                 out_enq__RDY,
    output logic                 busy
);

    localparam int BEATS   = (inWidth + dataWidth - 1) / dataWidth;
    localparam int IDXW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS_N = 2 ** IDXW;
    localparam int PADW    = BEATS * dataWidth;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [inWidth-1:0]   hold_q, hold_d;

    logic [PADW-1:0]      padded;
    logic [dataWidth-1:0] words [WORDS_N];
    logic                 last_word;

    // The held beat is widened with zeros so the last word picks up padding
    // above the top input bit.
    assign padded = PADW'(hold_q);

    // Slice the padded beat into words; slots beyond BEATS only exist to make
    // the word table a power of two and are never selected.
    for (genvar k = 0; k < WORDS_N; k++) begin : g_words
        if (k < BEATS) begin : g_real
            assign words[k] = padded[k*dataWidth +: dataWidth];
        end else begin : g_pad
            assign words[k] = '0;
        end
    end

    assign last_word = (idx_q == LAST_IDX);

    // Handshake outputs are combinational from state and the downstream ready,
    // so a new beat can be accepted as the last word leaves.
    always_comb begin
        out_enq__ENA = (state_q == SEND) && out_enq__RDY;
        out_enq_v    = (state_q == SEND) ? words[idx_q] : '0;
        in_enq__RDY  = (state_q == IDLE) ||
                       ((state_q == SEND) && last_word && out_enq__RDY);
        busy         = (state_q == SEND);
    end

    // Next-state logic: capture beats, advance the word index on each output
    // transfer, and either reload or fall back to IDLE after the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (in_enq__ENA) begin
                    hold_d  = in_enq_v;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_enq__RDY) begin
                    if (!last_word) begin
                        idx_d = idx_q + IDXW'(1);
                    end else if (in_enq__ENA) begin
                        hold_d = in_enq_v;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any beat still being funnelled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_pipe_in_funnel_tx.sv
// Directed testbench for pipe_in_funnel_tx at default parameters
// (144-bit beats funnelled into five 32-bit words).
module tb_pipe_in_funnel_tx;

    logic          CLK;
    logic          nRST;
    logic          in_ena;
    logic [143:0]  in_v;
    logic          in_rdy;
    logic          out_ena;
    logic [31:0]   out_v;
    logic          out_rdy;
    logic          busy;

    int n_compared;
    int n_mismatched;

    logic [143:0] beat_a;
    logic [143:0] beat_b;
    logic [31:0]  word_a [5];
    logic [31:0]  word_b [5];

    pipe_in_funnel_tx dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_enq__ENA  (in_ena),
        .in_enq_v     (in_v),
        .in_enq__RDY  (in_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq__RDY (out_rdy),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        in_ena = 1'b0;
        in_v = '0;
        out_rdy = 1'b1;
        repeat (3) tick();
        #1;
        n_compared++;
        if (out_ena !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_hold_ena: got %b want 0", out_ena);
        end
        nRST = 1'b1;
        tick();
        n_compared++;
        if (in_rdy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_rdy: got %b want 1", in_rdy);
        end
        n_compared++;
        if (out_ena !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_ena: got %b want 0", out_ena);
        end
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        n_compared++;
        if (out_v !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_v: got %h want 0", out_v);
        end
    endtask

    task automatic test_single_beat();
        out_rdy = 1'b1;
        in_ena = 1'b1;
        in_v = beat_a;
        tick();
        in_ena = 1'b0;
        in_v = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_compared++;
            if (out_ena !== 1'b1 || out_v !== word_a[k]) begin
                n_mismatched++;
                $display("[TB] FAIL single_word%0d: got ena=%b v=%h want ena=1 v=%h",
                         k, out_ena, out_v, word_a[k]);
            end
            n_compared++;
            if (in_rdy !== (k == 4)) begin
                n_mismatched++;
                $display("[TB] FAIL single_in_rdy%0d: got %b want %b", k, in_rdy, (k == 4));
            end
            tick();
        end
        n_compared++;
        if (busy !== 1'b0 || out_ena !== 1'b0 || in_rdy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_done: got busy=%b ena=%b rdy=%b want 0 0 1",
                     busy, out_ena, in_rdy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        in_ena = 1'b1;
        in_v = beat_a;
        out_rdy = 1'b1;
        tick();
        in_ena = 1'b0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            out_rdy = (c % 3 == 0);
            #1;
            n_compared++;
            if (out_ena !== out_rdy || out_v !== word_a[n]) begin
                n_mismatched++;
                $display("[TB] FAIL bp_cycle%0d: got ena=%b v=%h want ena=%b v=%h",
                         c, out_ena, out_v, out_rdy, word_a[n]);
            end
            n_compared++;
            if (in_rdy !== (n == 4 && out_rdy)) begin
                n_mismatched++;
                $display("[TB] FAIL bp_in_rdy%0d: got %b want %b", c, in_rdy, (n == 4 && out_rdy));
            end
            if (out_rdy) n++;
            tick();
        end
        n_compared++;
        if (n !== 5 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_done: got words=%0d busy=%b want 5 0", n, busy);
        end
        out_rdy = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_rdy = 1'b1;
        in_ena = 1'b1;
        in_v = beat_a;
        tick();
        in_ena = 1'b0;
        for (int c = 0; c < 10; c++) begin
            exp = (c < 5) ? word_a[c] : word_b[c-5];
            if (c == 4) begin
                in_ena = 1'b1;
                in_v = beat_b;
            end else begin
                in_ena = 1'b0;
                in_v = '0;
            end
            #1;
            n_compared++;
            if (out_ena !== 1'b1 || out_v !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_cycle%0d: got ena=%b v=%h want ena=1 v=%h",
                         c + 1, out_ena, out_v, exp);
            end
            tick();
        end
        in_ena = 1'b0;
        n_compared++;
        if (out_ena !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_done: got ena=%b busy=%b want 0 0", out_ena, busy);
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        in_ena = 1'b1;
        in_v = beat_a;
        tick();
        in_ena = 1'b0;
        repeat (3) tick();
        nRST = 1'b0;
        #1;
        n_compared++;
        if (out_ena !== 1'b0 || busy !== 1'b0 || out_v !== 32'h0 || in_rdy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_async: got ena=%b busy=%b v=%h rdy=%b want 0 0 0 1",
                     out_ena, busy, out_v, in_rdy);
        end
        tick();
        nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_compared++;
            if (out_ena !== 1'b0 || in_rdy !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL midrst_after%0d: got ena=%b rdy=%b want 0 1",
                         c, out_ena, in_rdy);
            end
            tick();
        end
    endtask

    task automatic test_illegal_enq();
        out_rdy = 1'b1;
        in_ena = 1'b1;
        in_v = beat_a;
        tick();
        in_ena = 1'b0;
        tick();
        in_ena = 1'b1;
        in_v = beat_b;
        #1;
        n_compared++;
        if (in_rdy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_in_rdy: got %b want 0", in_rdy);
        end
        tick();
        in_ena = 1'b0;
        in_v = '0;
        for (int k = 2; k < 5; k++) begin
            #1;
            n_compared++;
            if (out_ena !== 1'b1 || out_v !== word_a[k]) begin
                n_mismatched++;
                $display("[TB] FAIL illegal_word%0d: got ena=%b v=%h want ena=1 v=%h",
                         k, out_ena, out_v, word_a[k]);
            end
            tick();
        end
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_done: got busy=%b want 0", busy);
        end
    endtask

    // Test sequence.
    initial begin
        n_compared = 0;
        n_mismatched = 0;
        beat_a = 144'hABCD_00112233_44556677_8899AABB_CCDDEEFF;
        beat_b = 144'h1234_FEDCBA98_76543210_0F1E2D3C_4B5A6978;
        word_a[0] = 32'hCCDDEEFF;
        word_a[1] = 32'h8899AABB;
        word_a[2] = 32'h44556677;
        word_a[3] = 32'h00112233;
        word_a[4] = 32'h0000ABCD;
        word_b[0] = 32'h4B5A6978;
        word_b[1] = 32'h0F1E2D3C;
        word_b[2] = 32'h76543210;
        word_b[3] = 32'hFEDCBA98;
        word_b[4] = 32'h00001234;

        test_reset();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_illegal_enq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_in_funnel_tx.md
Name: pipe_in_funnel_tx

Overview:
- Transmit end of the PipeIn enq protocol: accepts one wide beat (16-bit header + 128-bit payload = 144 bits) on a PipeIn server port.
- Funnels that beat out as a sequence of narrow dataWidth words on a PipeIn client port, driving enq__ENA/enq$v into a downstream narrow PipeIn server.
- Sits between wide message producers and narrow PipeIn consumers; single clock domain.

Parameters:
- inWidth, 144, width of the wide input beat (16 + 128).
- dataWidth, 32, width of each output word; must satisfy 1 <= dataWidth <= inWidth.
- BEATS (derived, not overridable): (inWidth + dataWidth - 1) / dataWidth; 5 at defaults.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_enq__ENA  input  1  wide beat transfer strobe; producer asserts only while in_enq__RDY=1.
- in_enq$v  input  inWidth  wide beat data.
- in_enq__RDY  output  1  block can accept a wide beat this cycle.
- out_enq__ENA  output  1  narrow word transfer strobe to downstream server.
- out_enq$v  output  dataWidth  narrow word.
- out_enq__RDY  input  1  downstream server can accept a word this cycle.
- busy  output  1  a wide beat is held with words remaining.

Behaviour:
- Reset: asynchronous on nRST=0.
  - state=IDLE, idx=0, hold register=0.
  - out_enq__ENA=0, out_enq$v=0, busy=0, in_enq__RDY=1 (combinational from state).
- Reset mid-funnel discards remaining words; no partial output after release.
- States:
  - IDLE: nothing held.
  - SEND: hold register valid; idx in 0..BEATS-1 selects the next word.
- Word order: least-significant first.
  - Word k = hold[k*dataWidth +: dataWidth].
  - Final word zero-padded above bit inWidth-1. Defaults: word 4 = {16'h0, hold[143:128]}.
- Output handshake:
  - out_enq__ENA = (state==SEND) && out_enq__RDY.
  - out_enq$v = selected word while SEND, else 0.
  - Every cycle with out_enq__ENA=1 is exactly one transfer.
  - Never assert ENA without RDY.
- Input handshake:
  - in_enq__RDY = (state==IDLE) || (state==SEND && idx==BEATS-1 && out_enq__RDY). Combinational path from out_enq__RDY is allowed.
  - in_enq__ENA while RDY=0 is a protocol violation; ignored, data not captured.
- Transitions:
  - IDLE + in_enq__ENA: capture in_enq$v, idx<=0, ->SEND. First word appears on out_enq$v the next cycle (latency 1).
  - SEND, out transfer, idx<BEATS-1: idx<=idx+1.
  - SEND, out transfer, idx==BEATS-1, in_enq__ENA=1: capture new beat, idx<=0, stay SEND. No bubble, so back-to-back beats give continuous output.
  - SEND, out transfer, idx==BEATS-1, no in_enq__ENA: ->IDLE, idx<=0.
  - SEND, out_enq__RDY=0: hold state, idx and data unchanged; out_enq$v stable.
- busy = (state==SEND).
- BEATS==1 (dataWidth>=inWidth): behaves as a 1-deep registered pipe with the same rules.
- idx width = max(1, clog2(BEATS)); idx never exceeds BEATS-1 and wraps only through reload/IDLE.

Test Plan:
- Reset/idle: hold nRST=0 three cycles, release -> in_enq__RDY=1, out_enq__ENA=0, busy=0, out_enq$v=0.
- Single beat, out_enq__RDY=1 always, in_enq$v=144'h_ABCD_00112233_44556677_8899AABB_CCDDEEFF.
  - Cycles 1..5 out: 32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233, 32'h0000ABCD.
  - Then busy=0; in_enq__RDY=0 during cycles 1..4, 1 in cycle 5.
- Backpressure: same beat, out_enq__RDY toggling 1,0,0,1,...
  - Words emitted only on RDY=1 cycles, same order, none duplicated or dropped.
  - out_enq$v constant while RDY=0.
- Back-to-back: two beats, second offered with in_enq__ENA in the cycle word 4 of the first transfers.
  - 10 consecutive out_enq__ENA cycles, no bubble.
  - Second beat's word 0 in cycle 6.
- Reset mid-operation: nRST=0 after word 2 of a beat -> immediate out_enq__ENA=0; after release no remaining words of that beat appear; in_enq__RDY=1.
- Illegal enq: in_enq__ENA=1 while in_enq__RDY=0 (idx=1) -> hold register unchanged, sequence of current beat intact.
